// File: rtl/afe_filt_pkg.sv
// Shared constants, types and helpers for the self-trigger AFE filter chain.
// Holds widths, default inverse coefficients, the slot enum, sat16 and mul.
package afe_filt_pkg;

  localparam int COEF_W  = 18;
  localparam int STATE_W = 25;
  localparam int ACC_W   = 48;
  localparam int ST_LSB  = 15;
  localparam int OUT_LSB = 24;
  localparam int ST_MSB  = ST_LSB + STATE_W - 1;

  localparam logic signed [COEF_W-1:0] B0_DEF = 18'sd32768;
  localparam logic signed [COEF_W-1:0] B1_DEF = -18'sd61252;
  localparam logic signed [COEF_W-1:0] B2_DEF = 18'sd28514;
  localparam logic signed [COEF_W-1:0] A1_DEF = 18'sd63124;
  localparam logic signed [COEF_W-1:0] A2_DEF = -18'sd30382;

  localparam logic signed [STATE_W-1:0] ST_MAX =
    {1'b0, {(STATE_W-1){1'b1}}};
  localparam logic signed [STATE_W-1:0] ST_MIN =
    {1'b1, {(STATE_W-1){1'b0}}};

  typedef enum logic [2:0] {
    CI_B0 = 3'd0,
    CI_B1 = 3'd1,
    CI_B2 = 3'd2,
    CI_A1 = 3'd3,
    CI_A2 = 3'd4
  } coef_idx_e;

  typedef struct packed {
    logic [COEF_W-1:0] b0;
    logic [COEF_W-1:0] b1;
    logic [COEF_W-1:0] b2;
    logic [COEF_W-1:0] a1;
    logic [COEF_W-1:0] a2;
  } coef_set_t;

  localparam coef_set_t COEF_DEF = '{
    b0: B0_DEF,
    b1: B1_DEF,
    b2: B2_DEF,
    a1: A1_DEF,
    a2: A2_DEF
  };

  // Integer part of a 24-fraction accumulator, clamped to 16 bits.
  function automatic logic signed [15:0] sat16(
    input logic signed [ACC_W-1:0] acc
  );
    logic signed [ACC_W-OUT_LSB-1:0] hi;
    hi = acc[ACC_W-1:OUT_LSB];
    if (hi > 24'sd32767) return 16'sh7fff;
    else if (hi < -24'sd32768) return 16'sh8000;
    else return hi[15:0];
  endfunction

  function automatic logic signed [ACC_W-1:0] mul(
    input logic signed [STATE_W-1:0] s,
    input logic signed [COEF_W-1:0] c
  );
    logic signed [ACC_W-1:0] se;
    logic signed [ACC_W-1:0] ce;
    se = ACC_W'(s);
    ce = ACC_W'(c);
    return se * ce;
  endfunction

endpackage

// File: rtl/afe_integrator_model_if.sv
// Sample stream, coefficient bus and status of the AFE integrator model.
// master drives samples/coefficients, slave is the filter.
interface afe_integrator_model_if;
  import afe_filt_pkg::*;

  logic                     enable;
  logic                     x_valid;
  logic signed [15:0]       x;
  logic                     coef_we;
  logic [2:0]               coef_addr;
  logic signed [COEF_W-1:0] coef_wdata;
  logic                     coef_commit;
  logic signed [15:0]       y;
  logic                     y_valid;
  logic                     sat_flag;
  logic                     coef_pending;

  modport master (
    output enable, x_valid, x,
    output coef_we, coef_addr, coef_wdata, coef_commit,
    input  y, y_valid, sat_flag, coef_pending
  );

  modport slave (
    input  enable, x_valid, x,
    input  coef_we, coef_addr, coef_wdata, coef_commit,
    output y, y_valid, sat_flag, coef_pending
  );
endinterface

// File: rtl/afe_coef_bank.sv
// Shadow/active coefficient banks with write-first atomic commit.
// Ports: clk, rst, x_valid, coef write bus in; coef_pending, active set out.
module afe_coef_bank
  import afe_filt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              x_valid,
  input  logic              coef_we,
  input  logic [2:0]        coef_addr,
  input  logic [COEF_W-1:0] coef_wdata,
  input  logic              coef_commit,
  output logic              coef_pending,
  output coef_set_t         coef
);

  coef_set_t shadow;
  coef_set_t shadow_nx;
  coef_set_t active;

  always_comb begin
    shadow_nx = shadow;
    if (coef_we) begin
      unique case (1'b1)
        coef_addr == CI_B0: shadow_nx.b0 = coef_wdata;
        coef_addr == CI_B1: shadow_nx.b1 = coef_wdata;
        coef_addr == CI_B2: shadow_nx.b2 = coef_wdata;
        coef_addr == CI_A1: shadow_nx.a1 = coef_wdata;
        coef_addr == CI_A2: shadow_nx.a2 = coef_wdata;
        default: ;
      endcase
    end
  end

  // Copy only in a sample gap so no output mixes two banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow       <= COEF_DEF;
      active       <= COEF_DEF;
      coef_pending <= 1'b0;
    end else begin
      shadow <= shadow_nx;
      if (coef_pending && !x_valid) begin
        active       <= shadow_nx;
        coef_pending <= 1'b0;
      end else if (coef_commit) begin
        coef_pending <= 1'b1;
      end
    end
  end

  assign coef = active;

endmodule

// File: rtl/afe_integrator_model.sv
// Second-order IIR emulating the AFE integrator (inverse of the compensator).
// Ports: clk, reset (sync, active-high), bus (slave: samples, coefs, status).
module afe_integrator_model
  import afe_filt_pkg::*;
(
  input logic clk,
  input logic reset,
  afe_integrator_model_if.slave bus
);

  logic rst_q;
  always_ff @(posedge clk) rst_q <= reset;

  coef_set_t coef;
  logic      pend;

  afe_coef_bank u_bank (
    .clk          (clk),
    .rst          (rst_q),
    .x_valid      (bus.x_valid),
    .coef_we      (bus.coef_we),
    .coef_addr    (bus.coef_addr),
    .coef_wdata   (bus.coef_wdata),
    .coef_commit  (bus.coef_commit),
    .coef_pending (pend),
    .coef         (coef)
  );

  logic signed [15:0] x_q;
  logic               v_q;
  logic               en_q;

  always_ff @(posedge clk) begin
    if (rst_q) begin
      x_q  <= '0;
      v_q  <= 1'b0;
      en_q <= 1'b0;
    end else begin
      x_q  <= bus.x;
      v_q  <= bus.x_valid;
      en_q <= bus.enable;
    end
  end

  logic signed [15:0]        x_1, x_2;
  logic signed [STATE_W-1:0] y_1, y_2;
  logic signed [STATE_W-1:0] st_new;
  logic signed [ACC_W-1:0]   acc;
  logic                      ovf;

  always_comb begin
    acc = mul({x_q, 9'b0}, $signed(coef.b0))
        + mul({x_1, 9'b0}, $signed(coef.b1))
        + mul({x_2, 9'b0}, $signed(coef.b2))
        + mul(y_1, $signed(coef.a1))
        + mul(y_2, $signed(coef.a2));
  end

  // Output and state windows share their top bit, so one test covers both.
  assign ovf = acc[ACC_W-1:ST_MSB] != {(ACC_W-ST_MSB){acc[ST_MSB]}};
  assign st_new = ovf ? (acc[ACC_W-1] ? ST_MIN : ST_MAX)
                      : acc[ST_MSB:ST_LSB];

  logic signed [15:0] out_p;
  logic               vp;
  logic               satp;

  always_ff @(posedge clk) begin
    if (rst_q) begin
      x_1   <= '0;
      x_2   <= '0;
      y_1   <= '0;
      y_2   <= '0;
      out_p <= '0;
      vp    <= 1'b0;
      satp  <= 1'b0;
    end else begin
      vp   <= v_q;
      satp <= 1'b0;
      if (v_q) begin
        if (en_q) begin
          x_2   <= x_1;
          x_1   <= x_q;
          y_2   <= y_1;
          y_1   <= st_new;
          out_p <= sat16(acc);
          satp  <= ovf;
        end else begin
          out_p <= x_q;
        end
      end
    end
  end

  logic signed [15:0] y_r;
  logic               yv_r;
  logic               sat_r;

  always_ff @(posedge clk) begin
    if (rst_q) begin
      y_r   <= '0;
      yv_r  <= 1'b0;
      sat_r <= 1'b0;
    end else begin
      yv_r  <= vp;
      if (vp) y_r <= out_p;
      sat_r <= sat_r | (vp & satp);
    end
  end

  assign bus.y            = y_r;
  assign bus.y_valid      = yv_r;
  assign bus.sat_flag     = sat_r;
  assign bus.coef_pending = pend;

endmodule
